// File: rtl/demux_1by8_tdm.sv
// ---------------------------------------------------------------------------
// demux_1by8_tdm
// Registered 1:N time-division demultiplexer (N = 2**SEL_W lanes).
// Receive-side partner of a select-swept N:1 mux.
//   Manual mode (i_auto_en=0): each valid bit is routed to lane i_s, and all
//     other lanes are driven 0 on the next cycle.
//   Auto mode (i_auto_en=1): an internal slot counter walks the lanes. Bits
//     are gathered into a shadow register. When the last slot is written, the
//     full frame moves to o_y, and o_frame_valid pulses for one cycle.
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset, has priority
//   i_auto_en      1 = auto frame assembly, 0 = manual demux
//   i_frame_sync   auto mode: force the write slot to 0
//   i_din          serial data bit
//   i_din_valid    i_din qualifier
//   i_s            manual-mode lane select
//   o_y            parallel output lanes (registered)
//   o_frame_valid  one-cycle strobe: o_y holds a newly completed frame
//   o_slot         current auto-mode slot counter
// ---------------------------------------------------------------------------
module demux_1by8_tdm #(
    parameter int unsigned SEL_W = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_auto_en,
    input  logic                    i_frame_sync,
    input  logic                    i_din,
    input  logic                    i_din_valid,
    input  logic [SEL_W-1:0]        i_s,
    output logic [(2**SEL_W)-1:0]   o_y,
    output logic                    o_frame_valid,
    output logic [SEL_W-1:0]        o_slot
);

    localparam int unsigned N = 2 ** SEL_W;

    logic [N-1:0]     r_y;
    logic             r_frame_valid;
    logic [SEL_W-1:0] r_slot;
    logic [N-1:0]     r_shadow;
    logic             r_auto_prev;

    logic             w_mode_chg;
    logic [SEL_W-1:0] w_base_slot;
    logic [N-1:0]     w_base_shadow;
    logic [SEL_W-1:0] w_k;
    logic [N-1:0]     w_y_d;
    logic             w_fv_d;
    logic [SEL_W-1:0] w_slot_d;
    logic [N-1:0]     w_shadow_d;

    // A mode change discards any partial frame. The current bit is then
    // handled under the new mode, starting from a clean slot 0.
    assign w_mode_chg    = (i_auto_en != r_auto_prev);
    assign w_base_slot   = w_mode_chg ? '0 : r_slot;
    assign w_base_shadow = w_mode_chg ? '0 : r_shadow;
    assign w_k           = i_frame_sync ? '0 : w_base_slot;

    always_comb begin
        w_y_d      = r_y;
        w_fv_d     = 1'b0;
        w_slot_d   = w_base_slot;
        w_shadow_d = w_base_shadow;
        if (!i_auto_en) begin
            if (i_din_valid) begin
                w_y_d      = '0;
                w_y_d[i_s] = i_din;
            end
        end else if (i_din_valid) begin
            w_shadow_d      = w_base_shadow;
            w_shadow_d[w_k] = i_din;
            w_slot_d        = w_k + 1'b1;
            if (w_k == '1) begin
                // Last slot: publish the frame, including this bit, and restart.
                w_y_d      = w_shadow_d;
                w_fv_d     = 1'b1;
                w_shadow_d = '0;
            end
        end else if (i_frame_sync) begin
            w_slot_d   = '0;
            w_shadow_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_y           <= '0;
            r_frame_valid <= 1'b0;
            r_slot        <= '0;
            r_shadow      <= '0;
            // Track the live mode so the first cycle after reset is not seen as a switch.
            r_auto_prev   <= i_auto_en;
        end else begin
            r_y           <= w_y_d;
            r_frame_valid <= w_fv_d;
            r_slot        <= w_slot_d;
            r_shadow      <= w_shadow_d;
            r_auto_prev   <= i_auto_en;
        end
    end

    assign o_y           = r_y;
    assign o_frame_valid = r_frame_valid;
    assign o_slot        = r_slot;

endmodule

// File: tb/tb_demux_1by8_tdm.sv
module tb_demux_1by8_tdm;

    logic       clk;
    logic       rst;
    logic       auto_en;
    logic       frame_sync;
    logic       din;
    logic       din_valid;
    logic [2:0] s;
    logic [7:0] y;
    logic       fv;
    logic [2:0] slot;

    int total;
    int bad;

    demux_1by8_tdm #(.SEL_W(3)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_auto_en    (auto_en),
        .i_frame_sync (frame_sync),
        .i_din        (din),
        .i_din_valid  (din_valid),
        .i_s          (s),
        .o_y          (y),
        .o_frame_valid(fv),
        .o_slot       (slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        din        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        auto_en = 1'b0;
        idle();
        s = 3'd0;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (y !== 8'h00) begin
            bad++;
            $display("FAIL reset_y got=%h want=00", y);
        end
        total++;
        if (fv !== 1'b0) begin
            bad++;
            $display("FAIL reset_fv got=%b want=0", fv);
        end
        total++;
        if (slot !== 3'd0) begin
            bad++;
            $display("FAIL reset_slot got=%0d want=0", slot);
        end
    endtask

    task automatic test_manual();
        logic [7:0] exp;
        auto_en = 1'b0;
        for (int j = 0; j < 8; j++) begin
            s = 3'(j);
            din = 1'b1;
            din_valid = 1'b1;
            tick();
            exp = 8'h01 << j;
            total++;
            if (y !== exp || fv !== 1'b0) begin
                bad++;
                $display("FAIL manual_lane%0d got y=%h fv=%b want y=%h fv=0", j, y, fv, exp);
            end
        end
        // Hold with din_valid low.
        idle();
        s = 3'd2;
        tick();
        tick();
        total++;
        if (y !== 8'h80) begin
            bad++;
            $display("FAIL manual_hold got=%h want=80", y);
        end
        // A valid 0 clears every lane.
        din = 1'b0;
        din_valid = 1'b1;
        tick();
        idle();
        total++;
        if (y !== 8'h00) begin
            bad++;
            $display("FAIL manual_zero got=%h want=00", y);
        end
        total++;
        if (slot !== 3'd0) begin
            bad++;
            $display("FAIL manual_slot got=%0d want=0", slot);
        end
    endtask

    task automatic test_auto();
        logic [7:0] pat;
        pat = 8'h8D;
        auto_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = pat[i];
            din_valid = 1'b1;
            tick();
            total++;
            if (slot !== 3'((i + 1) % 8)) begin
                bad++;
                $display("FAIL auto_slot%0d got=%0d want=%0d", i, slot, (i + 1) % 8);
            end
            if (i < 7) begin
                total++;
                if (fv !== 1'b0) begin
                    bad++;
                    $display("FAIL auto_early_fv%0d got=%b want=0", i, fv);
                end
            end
        end
        idle();
        total++;
        if (y !== 8'h8D || fv !== 1'b1) begin
            bad++;
            $display("FAIL auto_frame got y=%h fv=%b want y=8d fv=1", y, fv);
        end
        tick();
        total++;
        if (fv !== 1'b0 || y !== 8'h8D) begin
            bad++;
            $display("FAIL auto_pulse_end got y=%h fv=%b want y=8d fv=0", y, fv);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] pat;
        pat = 8'h8D;
        auto_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                idle();
                for (int g = 0; g < 3; g++) begin
                    tick();
                    total++;
                    if (slot !== 3'd4 || fv !== 1'b0) begin
                        bad++;
                        $display("FAIL gap%0d got slot=%0d fv=%b want slot=4 fv=0", g, slot, fv);
                    end
                end
            end
            din = pat[i];
            din_valid = 1'b1;
            tick();
        end
        idle();
        total++;
        if (y !== 8'h8D || fv !== 1'b1) begin
            bad++;
            $display("FAIL gaps_frame got y=%h fv=%b want y=8d fv=1", y, fv);
        end
        tick();
    endtask

    task automatic test_resync();
        int pulses;
        pulses = 0;
        auto_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 1'b1;
            din_valid = 1'b1;
            tick();
            if (fv === 1'b1) pulses++;
        end
        frame_sync = 1'b1;
        din = 1'b0;
        din_valid = 1'b1;
        tick();
        frame_sync = 1'b0;
        if (fv === 1'b1) pulses++;
        total++;
        if (slot !== 3'd1) begin
            bad++;
            $display("FAIL resync_slot got=%0d want=1", slot);
        end
        for (int i = 0; i < 7; i++) begin
            din = 1'b1;
            din_valid = 1'b1;
            tick();
            if (fv === 1'b1) pulses++;
        end
        idle();
        total++;
        if (y !== 8'hFE || fv !== 1'b1) begin
            bad++;
            $display("FAIL resync_frame got y=%h fv=%b want y=fe fv=1", y, fv);
        end
        tick();
        if (fv === 1'b1) pulses++;
        total++;
        if (pulses !== 1) begin
            bad++;
            $display("FAIL resync_pulses got=%0d want=1", pulses);
        end
    endtask

    task automatic test_mode_switch();
        logic [7:0] pat;
        auto_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 1'b1;
            din_valid = 1'b1;
            tick();
        end
        idle();
        auto_en = 1'b0;
        tick();
        total++;
        if (slot !== 3'd0 || fv !== 1'b0 || y !== 8'hFE) begin
            bad++;
            $display("FAIL mode_switch got slot=%0d fv=%b y=%h want slot=0 fv=0 y=fe",
                     slot, fv, y);
        end
        // The first bit rides on the switch back and must land in slot 0.
        pat = 8'h5A;
        auto_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = pat[i];
            din_valid = 1'b1;
            tick();
        end
        idle();
        total++;
        if (y !== 8'h5A || fv !== 1'b1) begin
            bad++;
            $display("FAIL mode_switch_frame got y=%h fv=%b want y=5a fv=1", y, fv);
        end
        tick();
        // Reset mid-frame.
        for (int i = 0; i < 4; i++) begin
            din = 1'b1;
            din_valid = 1'b1;
            tick();
        end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (y !== 8'h00 || slot !== 3'd0 || fv !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid got y=%h slot=%0d fv=%b want y=00 slot=0 fv=0", y, slot, fv);
        end
        pat = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            din = pat[i];
            din_valid = 1'b1;
            tick();
        end
        idle();
        total++;
        if (y !== 8'hC3 || fv !== 1'b1) begin
            bad++;
            $display("FAIL rst_frame got y=%h fv=%b want y=c3 fv=1", y, fv);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        stream = 16'h3CA5;
        auto_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = stream[i];
            din_valid = 1'b1;
            tick();
            if (i == 7) begin
                total++;
                if (fv !== 1'b1 || y !== 8'hA5) begin
                    bad++;
                    $display("FAIL b2b_first got y=%h fv=%b want y=a5 fv=1", y, fv);
                end
            end else if (i == 15) begin
                total++;
                if (fv !== 1'b1 || y !== 8'h3C) begin
                    bad++;
                    $display("FAIL b2b_second got y=%h fv=%b want y=3c fv=1", y, fv);
                end
            end else begin
                total++;
                if (fv !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_nopulse%0d got=%b want=0", i, fv);
                end
            end
        end
        idle();
        tick();
        total++;
        if (fv !== 1'b0 || y !== 8'h3C) begin
            bad++;
            $display("FAIL b2b_after got y=%h fv=%b want y=3c fv=0", y, fv);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_manual();
        test_auto();
        test_gaps();
        test_resync();
        test_mode_switch();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
